// File: rtl/mem_if.sv
// Bundle of the microsequencer-side handshake and the instruction/data RAM ports.
// The slave modport is the mem_interface view; master is the controller/RAM-model view.
interface mem_if #(
  parameter int DAW = 16
);
  logic           mem_start;
  logic [2:0]     mem_op;
  logic [7:0]     pc;
  logic [DAW-1:0] ar;
  logic [7:0]     mbr_in;

  logic           iram_req;
  logic [7:0]     iram_addr;
  logic           iram_ack;
  logic [7:0]     iram_rdata;

  logic           dram_req;
  logic           dram_we;
  logic [DAW-1:0] dram_addr;
  logic [7:0]     dram_wdata;
  logic           dram_ack;
  logic [7:0]     dram_rdata;

  logic [7:0]     mbru;
  logic [7:0]     mbr;
  logic           busy;
  logic           done;
  logic           err;

  modport slave (
    input  mem_start, mem_op, pc, ar, mbr_in,
    input  iram_ack, iram_rdata, dram_ack, dram_rdata,
    output iram_req, iram_addr, dram_req, dram_we, dram_addr, dram_wdata,
    output mbru, mbr, busy, done, err
  );

  modport master (
    output mem_start, mem_op, pc, ar, mbr_in,
    output iram_ack, iram_rdata, dram_ack, dram_rdata,
    input  iram_req, iram_addr, dram_req, dram_we, dram_addr, dram_wdata,
    input  mbru, mbr, busy, done, err
  );
endinterface

// File: rtl/mem_interface.sv
// Memory access sequencer: turns a one-cycle mem_start/mem_op command into an
// instruction fetch, data read or data write handshake with an ack timeout.
module mem_interface #(
  parameter int TIMEOUT = 15,
  parameter int DAW     = 16
) (
  input  logic clk,
  input  logic rst_n,
  mem_if.slave bus
);

  typedef enum logic [2:0] {IDLE, IFETCH, DREAD, DWRITE, DONE} state_t;

  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t         state, next_state;
  logic [CW-1:0]  wait_cnt;
  logic [7:0]     pc_q;
  logic [DAW-1:0] ar_q;
  logic [7:0]     wdata_q;
  logic [7:0]     mbru_q;
  logic [7:0]     mbr_q;
  logic           err_q;

  logic in_req;
  logic ack;
  logic expired;
  logic op_bad;
  logic accept;

  // The request wait cycle that still sees no ack on count LAST is the
  // TIMEOUT-th one, so the request stays up for exactly TIMEOUT cycles.
  always_comb begin
    in_req  = (state == IFETCH) || (state == DREAD) || (state == DWRITE);
    ack     = 1'b0;
    case (state)
      IFETCH:        ack = bus.iram_ack;
      DREAD, DWRITE: ack = bus.dram_ack;
      default:       ack = 1'b0;
    endcase
    expired = in_req && !ack && (wait_cnt == LAST);
    op_bad  = (bus.mem_op != 3'b000) && (|(bus.mem_op & (bus.mem_op - 3'd1)));
    accept  = (state == IDLE) && bus.mem_start &&
              ((bus.mem_op == 3'b100) || (bus.mem_op == 3'b010) || (bus.mem_op == 3'b001));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.mem_start) begin
          case (bus.mem_op)
            3'b100:  next_state = IFETCH;
            3'b010:  next_state = DREAD;
            3'b001:  next_state = DWRITE;
            default: next_state = IDLE;
          endcase
        end
      end
      IFETCH, DREAD, DWRITE: begin
        if (ack || expired) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.iram_req   = 1'b0;
    bus.iram_addr  = '0;
    bus.dram_req   = 1'b0;
    bus.dram_we    = 1'b0;
    bus.dram_addr  = '0;
    bus.dram_wdata = '0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    case (state)
      IFETCH: begin
        bus.iram_req  = 1'b1;
        bus.iram_addr = pc_q;
        bus.busy      = 1'b1;
      end
      DREAD: begin
        bus.dram_req  = 1'b1;
        bus.dram_addr = ar_q;
        bus.busy      = 1'b1;
      end
      DWRITE: begin
        bus.dram_req   = 1'b1;
        bus.dram_we    = 1'b1;
        bus.dram_addr  = ar_q;
        bus.dram_wdata = wdata_q;
        bus.busy       = 1'b1;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, wait counter, load targets and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      ar_q     <= '0;
      wdata_q  <= '0;
      wait_cnt <= '0;
      mbru_q   <= '0;
      mbr_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        pc_q    <= bus.pc;
        ar_q    <= bus.ar;
        wdata_q <= bus.mbr_in;
      end
      if (!in_req)                      wait_cnt <= '0;
      else if (!ack && !expired)        wait_cnt <= wait_cnt + 1'b1;
      if (state == IFETCH && ack)       mbru_q <= bus.iram_rdata;
      if (state == DREAD && ack)        mbr_q  <= bus.dram_rdata;
      if (expired || (bus.mem_start && (in_req || (state == IDLE && op_bad))))
        err_q <= 1'b1;
    end
  end

  assign bus.mbru = mbru_q;
  assign bus.mbr  = mbr_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_mem_interface.sv
// Randomized bench for mem_interface: a transaction-level model predicts request
// length, loaded bytes and the sticky error flag for every command issued.
module tb_mem_interface;

  localparam int TIMEOUT = 15;
  localparam int DAW     = 16;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   passCount;

  logic [7:0] mbruExp;
  logic [7:0] mbrExp;
  logic       errExp;

  mem_if #(.DAW(DAW)) bus ();

  mem_interface #(.TIMEOUT(TIMEOUT), .DAW(DAW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    else
      passCount++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearModel();
    mbruExp = 8'h00;
    mbrExp  = 8'h00;
    errExp  = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_req"},  {29'd0, bus.iram_req, bus.dram_req, bus.dram_we}, 32'd0);
    checkOutput({tag, "_busy"}, {30'd0, bus.busy, bus.done}, 32'd0);
    checkOutput({tag, "_err"},  {31'd0, bus.err}, {31'd0, errExp});
    checkOutput({tag, "_regs"}, {16'd0, bus.mbru, bus.mbr}, {16'd0, mbruExp, mbrExp});
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_req"},  {29'd0, bus.iram_req, bus.dram_req, bus.dram_we}, 32'd0);
    checkOutput({tag, "_busy"}, {30'd0, bus.busy, bus.done}, 32'd0);
    checkOutput({tag, "_data"}, {15'd0, bus.mbru, bus.mbr, bus.err}, 32'd0);
    checkOutput({tag, "_addr"}, {bus.iram_addr, bus.dram_addr, bus.dram_wdata}, 32'd0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    clearModel();
    checkAllZero("reset");
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // A command that must not start an access (000 or non-one-hot)
  task automatic applyStimulusNoAccess(input logic [2:0] op);
    bus.mem_start = 1'b1;
    bus.mem_op    = op;
    tick();
    bus.mem_start = 1'b0;
    bus.mem_op    = 3'b000;
    if (op != 3'b000) errExp = 1'b1;
    checkIdle("noacc");
  endtask

  // One access: ack arrives in request cycle d+1 (none if d >= TIMEOUT);
  // resetAt > 0 pulls rst_n low in that request cycle instead.
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] pcv, input logic [15:0] arv,
                               input logic [7:0] wd, input int d, input logic [7:0] rd,
                               input bit overlap, input bit doneStart, input int resetAt);
    int  nreq;
    bit  ackNow;
    bus.mem_start = 1'b1;
    bus.mem_op    = op;
    bus.pc        = pcv;
    bus.ar        = arv;
    bus.mbr_in    = wd;
    tick();
    bus.mem_start = 1'b0;
    bus.mem_op    = 3'b000;
    bus.pc        = 8'($urandom);
    bus.ar        = 16'($urandom);
    bus.mbr_in    = 8'($urandom);
    nreq = (d < TIMEOUT) ? d + 1 : TIMEOUT;
    for (int k = 1; k <= nreq; k++) begin
      if (resetAt == k) begin
        rst_n         = 1'b0;
        bus.iram_ack  = 1'b0;
        bus.dram_ack  = 1'b0;
        #1;
        clearModel();
        checkAllZero("rstMid");
        tick();
        checkOutput("rstNoDone", {31'd0, bus.done}, 32'd0);
        rst_n = 1'b1;
        return;
      end
      checkOutput("busy", {31'd0, bus.busy}, 32'd1);
      checkOutput("doneEarly", {31'd0, bus.done}, 32'd0);
      ackNow = (k == d + 1);
      case (op)
        3'b100: begin
          checkOutput("fetchReq", {29'd0, bus.iram_req, bus.dram_req, bus.dram_we}, 32'b100);
          checkOutput("fetchAddr", {24'd0, bus.iram_addr}, {24'd0, pcv});
          bus.iram_ack   = ackNow;
          bus.iram_rdata = ackNow ? rd : 8'($urandom);
          bus.dram_ack   = 1'($urandom);
          bus.dram_rdata = 8'($urandom);
        end
        3'b010: begin
          checkOutput("readReq", {29'd0, bus.iram_req, bus.dram_req, bus.dram_we}, 32'b010);
          checkOutput("readAddr", {16'd0, bus.dram_addr}, {16'd0, arv});
          bus.dram_ack   = ackNow;
          bus.dram_rdata = ackNow ? rd : 8'($urandom);
          bus.iram_ack   = 1'($urandom);
          bus.iram_rdata = 8'($urandom);
        end
        default: begin
          checkOutput("writeReq", {29'd0, bus.iram_req, bus.dram_req, bus.dram_we}, 32'b011);
          checkOutput("writeAddr", {16'd0, bus.dram_addr}, {16'd0, arv});
          checkOutput("writeData", {24'd0, bus.dram_wdata}, {24'd0, wd});
          bus.dram_ack   = ackNow;
          bus.dram_rdata = 8'($urandom);
          bus.iram_ack   = 1'($urandom);
          bus.iram_rdata = 8'($urandom);
        end
      endcase
      if (overlap && k == 1) begin
        bus.mem_start = 1'b1;
        bus.mem_op    = 3'($urandom);
        errExp        = 1'b1;
      end
      tick();
      bus.mem_start = 1'b0;
      bus.mem_op    = 3'b000;
      bus.iram_ack  = 1'b0;
      bus.dram_ack  = 1'b0;
    end
    if (d < TIMEOUT) begin
      if (op == 3'b100) mbruExp = rd;
      if (op == 3'b010) mbrExp  = rd;
    end else begin
      errExp = 1'b1;
    end
    checkOutput("donePulse", {30'd0, bus.done, bus.busy}, 32'b10);
    checkOutput("doneReq", {29'd0, bus.iram_req, bus.dram_req, bus.dram_we}, 32'd0);
    checkOutput("doneErr", {31'd0, bus.err}, {31'd0, errExp});
    checkOutput("doneRegs", {16'd0, bus.mbru, bus.mbr}, {16'd0, mbruExp, mbrExp});
    if (doneStart) begin
      bus.mem_start = 1'b1;
      bus.mem_op    = 3'b010;
    end
    tick();
    bus.mem_start = 1'b0;
    bus.mem_op    = 3'b000;
    checkIdle("afterDone");
  endtask

  initial begin
    int r;
    int d;
    int nreq;
    logic [2:0] op;
    logic [2:0] legalOps [3];
    logic [2:0] badOps [5];
    legalOps = '{3'b100, 3'b010, 3'b001};
    badOps   = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
    checkCount     = 0;
    passCount      = 0;
    rst_n          = 1'b0;
    bus.mem_start  = 1'b0;
    bus.mem_op     = 3'b000;
    bus.pc         = 8'h00;
    bus.ar         = 16'h0000;
    bus.mbr_in     = 8'h00;
    bus.iram_ack   = 1'b0;
    bus.iram_rdata = 8'h00;
    bus.dram_ack   = 1'b0;
    bus.dram_rdata = 8'h00;
    clearModel();
    tick();
    doReset();

    // Directed scenarios from the block's acceptance list
    applyStimulus(3'b100, 8'h05, 16'h0000, 8'h00, 1, 8'h1F, 1'b0, 1'b0, 0);
    applyStimulus(3'b001, 8'h00, 16'h0123, 8'hA5, 0, 8'h00, 1'b0, 1'b0, 0);
    applyStimulus(3'b010, 8'h00, 16'h0123, 8'h00, 0, 8'hA5, 1'b0, 1'b0, 0);
    applyStimulus(3'b010, 8'h00, 16'h0456, 8'h00, TIMEOUT + 3, 8'h00, 1'b0, 1'b0, 0);
    doReset();
    applyStimulusNoAccess(3'b000);
    applyStimulusNoAccess(3'b110);
    doReset();
    applyStimulus(3'b010, 8'h00, 16'h0777, 8'h00, 2, 8'h3C, 1'b1, 1'b1, 0);
    doReset();
    applyStimulus(3'b001, 8'h00, 16'h0999, 8'h5A, 10, 8'h00, 1'b0, 1'b0, 2);
    applyStimulus(3'b100, 8'h42, 16'h0000, 8'h00, 0, 8'h99, 1'b0, 1'b0, 0);

    // Randomized traffic; frequent resets keep the sticky err observable
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 11);
      if (r == 0) begin
        doReset();
      end else if (r == 1) begin
        applyStimulusNoAccess(badOps[$urandom_range(0, 4)]);
      end else begin
        op   = legalOps[$urandom_range(0, 2)];
        d    = ($urandom_range(0, 5) == 0) ? $urandom_range(0, TIMEOUT + 2) : $urandom_range(0, 3);
        nreq = (d < TIMEOUT) ? d + 1 : TIMEOUT;
        applyStimulus(op, 8'($urandom), 16'($urandom), 8'($urandom), d, 8'($urandom),
                      ($urandom_range(0, 7) == 0), 1'($urandom),
                      ($urandom_range(0, 9) == 0) ? $urandom_range(1, nreq) : 0);
      end
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_interface.md
MEM_INTERFACE -- requirements
Module: mem_interface

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: max cycles to wait for a RAM ack before abort.
REQ-002 SHALL have parameter DAW, default 16: data-RAM address width.
REQ-003 clk  input  1  single clock; all state on posedge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 mem_start  input  1  one-cycle pulse; qualifies mem_op.
REQ-006 mem_op  input  3  microinstruction memory field {fetch,read,write}; legal values 100, 010, 001.
REQ-007 pc  input  8  instruction address.
REQ-008 ar  input  DAW  data address.
REQ-009 mbr_in  input  8  store data from datapath.
REQ-010 iram_req / iram_addr  output  1 / 8  instruction-RAM request and address.
REQ-011 iram_ack / iram_rdata  input  1 / 8  instruction-RAM acknowledge and read data.
REQ-012 dram_req / dram_we / dram_addr / dram_wdata  output  1 / 1 / DAW / 8  data-RAM request, write enable, address, write data.
REQ-013 dram_ack / dram_rdata  input  1 / 8  data-RAM acknowledge and read data.
REQ-014 mbru  output  8  fetched opcode byte, consumed as next microaddress.
REQ-015 mbr  output  8  loaded pixel/data byte.
REQ-016 busy  output  1  high from the cycle after an accepted mem_start until done.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 err  output  1  sticky error flag.

Function
REQ-019 FSM states SHALL be IDLE, IFETCH, DREAD, DWRITE, DONE.
REQ-020 In IDLE, mem_start=1 with mem_op 100/010/001 SHALL, next cycle, enter IFETCH/DREAD/DWRITE respectively, latching pc, ar and mbr_in into internal registers.
REQ-021 mem_start with mem_op 000 SHALL be ignored, with no state change and no err.
REQ-022 mem_start with any non-one-hot nonzero mem_op SHALL set err and remain IDLE.
REQ-023 mem_start while busy SHALL be ignored and SHALL set err.
REQ-024 IFETCH SHALL hold iram_req=1 and iram_addr=latched pc until iram_ack.
- On iram_ack: mbru <= iram_rdata in the same edge; then go to DONE.
REQ-025 DREAD SHALL hold dram_req=1, dram_we=0, dram_addr=latched ar until dram_ack.
- On dram_ack: mbr <= dram_rdata; then go to DONE.
REQ-026 DWRITE SHALL hold dram_req=1, dram_we=1, dram_addr=latched ar, dram_wdata=latched mbr_in until dram_ack; then go to DONE.
REQ-027 An ack arriving in the first request cycle SHALL be accepted, giving minimum latency of 3 cycles from mem_start to done.
REQ-028 A wait counter SHALL clear on entry to IFETCH/DREAD/DWRITE and increment each cycle without ack.
- If the count reaches TIMEOUT: drop req, set err, go to DONE, leave mbru/mbr unchanged.
REQ-029 DONE SHALL assert done=1 and busy=0 for exactly one cycle, then return to IDLE.
- A mem_start in the DONE cycle SHALL be ignored without err.
REQ-030 Acks not matching the active request (e.g. dram_ack in IFETCH or IDLE) SHALL be ignored.
REQ-031 Outside their own states, iram_req, dram_req and dram_we SHALL be 0.
REQ-032 mbru and mbr SHALL hold their last values until overwritten by a completed access.
REQ-033 err SHALL clear only on reset.

Reset
REQ-034 rst_n=0 SHALL immediately force state IDLE, wait counter 0, and mbru, mbr, busy, done, err, all req/we outputs and all address/data outputs to 0.
REQ-035 Reset asserted mid-access SHALL abort the access with no done pulse; after release, the block SHALL accept mem_start on the first clock edge.

Verification
REQ-036 Fetch: pc=8'h05, mem_start with 100, iram_ack on the 2nd request cycle with rdata 8'h1F -> mbru=8'h1F, done pulses 4 cycles after mem_start, err=0.
REQ-037 Load/store: write 8'hA5 to ar=16'h0123 (ack immediate), then read ar=16'h0123 with dram_rdata=8'hA5 -> dram_we=1 only during the write, mbr=8'hA5, each op done at cycle 3.
REQ-038 Timeout: mem_start with 010, no dram_ack -> dram_req drops after exactly 15 cycles, err=1, done pulses, mbr unchanged.
REQ-039 Illegal/overlap: mem_op=110 -> err=1, no req; separately, mem_start during DREAD -> err=1 and the read completes normally.
REQ-040 Reset mid-write: rst_n low in cycle 2 of DWRITE -> dram_req=0 immediately, no done, all outputs 0; fetch after release completes normally.
